// File: rtl/nf_id_stage.sv
// nf_id_stage: registered RV32I decode stage between fetch and execute.
// Resolves branches and jumps in ID, forwards WB data and interlocks on load-use hazards.
module nf_id_stage #(
    parameter int XLEN     = 32,
    parameter bit FWD_WB   = 1'b1,
    parameter bit LU_STALL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            if_valid,
    output logic            id_ready,
    input  logic            flush,
    output logic [4:0]      ra1,
    output logic [4:0]      ra2,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic            wb_we,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    output logic            pc_b_en,
    output logic [XLEN-1:0] pc_target,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [4:0]      ex_wa3,
    output logic [3:0]      ex_alu_code,
    output logic            ex_srcB_sel,
    output logic            ex_srcA_pc,
    output logic            ex_we_rf,
    output logic            ex_we_dm,
    output logic            ex_is_load,
    output logic            ex_illegal,
    output logic [2:0]      ex_funct3
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32       = {XLEN{v[31]}};
        sext32[31:0] = v;
    endfunction

    // alt selects SUB/SRA (instr[30]) where the encoding allows it
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_of = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_of = ALU_SLL;
            3'd2:    alu_of = ALU_SLT;
            3'd3:    alu_of = ALU_SLTU;
            3'd4:    alu_of = ALU_XOR;
            3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] wa3;
    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];
    assign wa3    = if_instr[11:7];
    assign ra1    = if_instr[19:15];
    assign ra2    = if_instr[24:20];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

    logic [XLEN-1:0] opnd1, opnd2;
    assign opnd1 = (FWD_WB && wb_we && (wb_wa != 5'd0) && (wb_wa == ra1)) ? wb_wd : rd1;
    assign opnd2 = (FWD_WB && wb_we && (wb_wa != 5'd0) && (wb_wa == ra2)) ? wb_wd : rd2;

    logic [XLEN-1:0] imm_d;
    logic [31:0]     tgt_imm;
    logic [3:0]      alu_d;
    logic            srcb_d, srca_d, wr_d, dm_d, ld_d, ill_d;
    logic            use_rs1, use_rs2, is_jump, is_jalr, is_br;

    // Jumps hand EX an immediate of 4 so the ALU forms the link address pc+4.
    always_comb begin
        imm_d   = '0;
        tgt_imm = '0;
        alu_d   = ALU_ADD;
        srcb_d  = 1'b0;
        srca_d  = 1'b0;
        wr_d    = 1'b0;
        dm_d    = 1'b0;
        ld_d    = 1'b0;
        ill_d   = 1'b0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        is_jump = 1'b0;
        is_jalr = 1'b0;
        is_br   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm_d = sext32(imm_u); alu_d = ALU_PASS_B; srcb_d = 1'b1; wr_d = 1'b1; use_rs1 = 1'b0;
            end
            OPC_AUIPC: begin
                imm_d = sext32(imm_u); srca_d = 1'b1; srcb_d = 1'b1; wr_d = 1'b1; use_rs1 = 1'b0;
            end
            OPC_JAL: begin
                imm_d = {{(XLEN-3){1'b0}}, 3'd4}; srca_d = 1'b1; srcb_d = 1'b1; wr_d = 1'b1;
                use_rs1 = 1'b0; is_jump = 1'b1; tgt_imm = imm_j;
            end
            OPC_JALR: begin
                imm_d = {{(XLEN-3){1'b0}}, 3'd4}; srca_d = 1'b1; srcb_d = 1'b1; wr_d = 1'b1;
                is_jump = 1'b1; is_jalr = 1'b1; tgt_imm = imm_i;
            end
            OPC_BRANCH: begin
                imm_d = sext32(imm_b); alu_d = ALU_SUB; use_rs2 = 1'b1; is_br = 1'b1;
                tgt_imm = imm_b; ill_d = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                imm_d = sext32(imm_i); srcb_d = 1'b1; wr_d = 1'b1; ld_d = 1'b1;
            end
            OPC_STORE: begin
                imm_d = sext32(imm_s); srcb_d = 1'b1; dm_d = 1'b1; use_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                imm_d = sext32(imm_i); srcb_d = 1'b1; wr_d = 1'b1;
                alu_d = alu_of(funct3, (funct3 == 3'd5) && funct7[5]);
            end
            OPC_OP: begin
                alu_d = alu_of(funct3, funct7[5]); wr_d = 1'b1; use_rs2 = 1'b1;
                ill_d = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
            default: ill_d = 1'b1;
        endcase
    end

    logic taken;
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'd0:    taken = (opnd1 == opnd2);
            3'd1:    taken = (opnd1 != opnd2);
            3'd4:    taken = ($signed(opnd1) <  $signed(opnd2));
            3'd5:    taken = ($signed(opnd1) >= $signed(opnd2));
            3'd6:    taken = (opnd1 <  opnd2);
            3'd7:    taken = (opnd1 >= opnd2);
            default: taken = 1'b0;
        endcase
    end

    logic [XLEN-1:0] tgt_sum;
    assign tgt_sum   = (is_jalr ? opnd1 : if_pc) + sext32(tgt_imm);
    assign pc_target = is_jalr ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;

    logic ex_valid_q, ex_is_load_q;
    logic [4:0] ex_wa3_q;
    logic adv, stall, transfer;

    // Handshake: a word moves from fetch when if_valid & id_ready, and leaves
    // the output register when ex_valid & ex_ready; the register reloads only when adv.
    assign adv      = !ex_valid_q || ex_ready;
    assign stall    = LU_STALL && if_valid && ex_valid_q && ex_is_load_q && (ex_wa3_q != 5'd0)
                      && ((use_rs1 && (ra1 == ex_wa3_q)) || (use_rs2 && (ra2 == ex_wa3_q)));
    assign id_ready = adv && !stall && !flush;
    assign transfer = if_valid && id_ready;
    assign pc_b_en  = transfer && (is_jump || (is_br && taken));

    logic [XLEN-1:0] ex_pc_q, ex_imm_q, ex_rd1_q, ex_rd2_q;
    logic [3:0]      ex_alu_q;
    logic            ex_srcb_q, ex_srca_q, ex_we_rf_q, ex_we_dm_q, ex_ill_q;
    logic [2:0]      ex_funct3_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_imm_q     <= '0;
            ex_rd1_q     <= '0;
            ex_rd2_q     <= '0;
            ex_wa3_q     <= '0;
            ex_alu_q     <= '0;
            ex_srcb_q    <= 1'b0;
            ex_srca_q    <= 1'b0;
            ex_we_rf_q   <= 1'b0;
            ex_we_dm_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_ill_q     <= 1'b0;
            ex_funct3_q  <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (adv) begin
            if (transfer) begin
                ex_valid_q   <= 1'b1;
                ex_pc_q      <= if_pc;
                ex_imm_q     <= imm_d;
                ex_rd1_q     <= opnd1;
                ex_rd2_q     <= opnd2;
                ex_wa3_q     <= wa3;
                ex_alu_q     <= alu_d;
                ex_srcb_q    <= srcb_d;
                ex_srca_q    <= srca_d;
                ex_we_rf_q   <= wr_d && (wa3 != 5'd0) && !ill_d;
                ex_we_dm_q   <= dm_d && !ill_d;
                ex_is_load_q <= ld_d;
                ex_ill_q     <= ill_d;
                ex_funct3_q  <= funct3;
            end else begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rd1      = ex_rd1_q;
    assign ex_rd2      = ex_rd2_q;
    assign ex_wa3      = ex_wa3_q;
    assign ex_alu_code = ex_alu_q;
    assign ex_srcB_sel = ex_srcb_q;
    assign ex_srcA_pc  = ex_srca_q;
    assign ex_we_rf    = ex_we_rf_q;
    assign ex_we_dm    = ex_we_dm_q;
    assign ex_is_load  = ex_is_load_q;
    assign ex_illegal  = ex_ill_q;
    assign ex_funct3   = ex_funct3_q;

endmodule

// File: tb/tb_nf_id_stage.sv
// Bench for nf_id_stage: directed decode scenarios plus randomized traffic against
// a reference decoder, with a queue-based scoreboard on the EX handshake.
module tb_nf_id_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  wa3;
        logic [3:0]  alu;
        logic        srcb;
        logic        srca;
        logic        we_rf;
        logic        we_dm;
        logic        is_load;
        logic        illegal;
        logic [2:0]  funct3;
    } bundle_t;
    localparam int W = $bits(bundle_t);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        if_valid = 1'b0;
    logic        id_ready;
    logic        flush = 1'b0;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_wa = '0;
    logic [31:0] wb_wd = '0;
    logic        pc_b_en;
    logic [31:0] pc_target;
    logic        ex_ready = 1'b1;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_rd1, ex_rd2;
    logic [4:0]  ex_wa3;
    logic [3:0]  ex_alu_code;
    logic        ex_srcB_sel, ex_srcA_pc, ex_we_rf, ex_we_dm, ex_is_load, ex_illegal;
    logic [2:0]  ex_funct3;

    nf_id_stage dut (
        .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .id_ready(id_ready), .flush(flush), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .pc_b_en(pc_b_en), .pc_target(pc_target),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_wa3(ex_wa3), .ex_alu_code(ex_alu_code),
        .ex_srcB_sel(ex_srcB_sel), .ex_srcA_pc(ex_srcA_pc), .ex_we_rf(ex_we_rf),
        .ex_we_dm(ex_we_dm), .ex_is_load(ex_is_load), .ex_illegal(ex_illegal),
        .ex_funct3(ex_funct3)
    );

    // clock/reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_v, exp_v;
    bit      m_valid = 0;
    bundle_t m_b;
    logic [6:0] opc_tab [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h03, 7'h7F, 7'h0B};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference decoder, straight from the RV32I field definitions
    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input bit alt);
        logic [3:0] tab [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd7;
        return tab[f3];
    endfunction

    function automatic void ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] o1, input logic [31:0] o2,
                                       output bundle_t b, output bit tk,
                                       output logic [31:0] tgt, output bit u1, output bit u2);
        int imm_i, imm_s, imm_b, imm_j;
        bit wr, ill;
        logic [2:0] f3;
        f3 = i[14:12];
        imm_i = int'($signed(i[31:20]));
        imm_s = int'($signed({i[31:25], i[11:7]}));
        imm_b = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        imm_j = int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        b = '0;
        b.pc = pc; b.rd1 = o1; b.rd2 = o2; b.wa3 = i[11:7]; b.funct3 = f3;
        tk = 0; tgt = '0; u1 = 1; u2 = 0; wr = 0; ill = 0;
        case (i[6:0])
            7'h37: begin b.imm = i & 32'hFFFFF000; b.alu = 4'd10; b.srcb = 1; wr = 1; u1 = 0; end
            7'h17: begin b.imm = i & 32'hFFFFF000; b.srca = 1; b.srcb = 1; wr = 1; u1 = 0; end
            7'h6F: begin
                b.imm = 4; b.srca = 1; b.srcb = 1; wr = 1; u1 = 0; tk = 1; tgt = pc + imm_j;
            end
            7'h67: begin
                b.imm = 4; b.srca = 1; b.srcb = 1; wr = 1; tk = 1; tgt = (o1 + imm_i) & ~32'd1;
            end
            7'h63: begin
                b.imm = imm_b; b.alu = 4'd1; u2 = 1; tgt = pc + imm_b;
                case (f3)
                    3'd0: tk = (o1 == o2);
                    3'd1: tk = (o1 != o2);
                    3'd4: tk = ($signed(o1) < $signed(o2));
                    3'd5: tk = ($signed(o1) >= $signed(o2));
                    3'd6: tk = (o1 < o2);
                    3'd7: tk = (o1 >= o2);
                    default: ill = 1;
                endcase
            end
            7'h03: begin b.imm = imm_i; b.srcb = 1; wr = 1; b.is_load = 1; end
            7'h23: begin b.imm = imm_s; b.srcb = 1; b.we_dm = 1; u2 = 1; end
            7'h13: begin b.imm = imm_i; b.srcb = 1; wr = 1; b.alu = ref_alu(f3, f3 == 3'd5 && i[30]); end
            7'h33: begin
                b.alu = ref_alu(f3, i[30]); wr = 1; u2 = 1;
                ill = !(i[31:25] == 7'h00 || i[31:25] == 7'h20);
            end
            default: ill = 1;
        endcase
        if (ill) begin tk = 0; b.we_dm = 0; end
        b.illegal = ill;
        b.we_rf = wr && (i[11:7] != 0) && !ill;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rd);
        return (wb_we && wb_wa != 0 && wb_wa == r) ? wb_wd : rd;
    endfunction

    // driver tasks: inputs change at posedge+1, model and checks run at negedge
    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step();
        bundle_t b;
        bit tk, u1, u2, adv, stall, rdy, xfer;
        logic [31:0] tgt;
        logic [4:0] r1, r2;
        r1 = if_instr[19:15];
        r2 = if_instr[24:20];
        ref_decode(if_instr, if_pc, fwd(r1, rd1), fwd(r2, rd2), b, tk, tgt, u1, u2);
        adv   = !m_valid || ex_ready;
        stall = if_valid && m_valid && m_b.is_load && m_b.wa3 != 0
                && ((u1 && r1 == m_b.wa3) || (u2 && r2 == m_b.wa3));
        rdy   = adv && !stall && !flush;
        xfer  = if_valid && rdy;
        chk("ra1", ra1, r1);
        chk("ra2", ra2, r2);
        chk("ex_valid", ex_valid, m_valid);
        chk("id_ready", id_ready, rdy);
        chk("pc_b_en", pc_b_en, xfer && tk);
        if (xfer && tk) chk("pc_target", pc_target, tgt);
        if (flush) begin
            if (m_valid && !ex_ready) void'(exp_q.pop_back());
            m_valid = 0;
        end else if (adv) begin
            if (xfer) begin
                m_b = b;
                m_valid = 1;
                exp_q.push_back(b);
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic cycle();
        to_neg();
        model_step();
        to_next();
    endtask

    task automatic idle();
        if_valid = 0; flush = 0; wb_we = 0; ex_ready = 1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom();
        i[6:0]   = opc_tab[$urandom_range(0, 11)];
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        i[11:7]  = 5'($urandom_range(0, 7));
        if (i[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0, 1:    i[31:25] = 7'h00;
                2:       i[31:25] = 7'h20;
                default: i[31:25] = 7'($urandom());
            endcase
        end
        return i;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && ex_valid && ex_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bundle_unexpected: got bundle with pc %h, expected none", ex_pc);
            end else begin
                exp_v = exp_q.pop_front();
                got_v = {ex_pc, ex_imm, ex_rd1, ex_rd2, ex_wa3, ex_alu_code, ex_srcB_sel,
                         ex_srcA_pc, ex_we_rf, ex_we_dm, ex_is_load, ex_illegal, ex_funct3};
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL bundle: got %h expected %h", got_v, exp_v);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        reset = 0;
        #1;
        chk("rst_id_ready", id_ready, 1);
        chk("rst_pc_b_en", pc_b_en, 0);
        chk("rst_ex_imm", ex_imm, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_ex_we_rf", ex_we_rf, 0);
        to_next();

        // ADDI x5,x0,-1 at 0x100
        idle(); if_valid = 1; if_instr = 32'hFFF00293; if_pc = 32'h100;
        cycle();
        idle();
        chk("addi_valid", ex_valid, 1);
        chk("addi_imm", ex_imm, 32'hFFFFFFFF);
        chk("addi_wa3", ex_wa3, 5);
        chk("addi_we_rf", ex_we_rf, 1);
        chk("addi_srcb", ex_srcB_sel, 1);
        chk("addi_alu", ex_alu_code, 0);
        cycle();

        // load-use: LW x6,0(x1) then ADD x7,x6,x2
        idle(); if_valid = 1; if_instr = 32'h0000A303; if_pc = 32'h104;
        cycle();
        if_instr = 32'h002303B3; if_pc = 32'h108;
        to_neg();
        chk("lu_id_ready", id_ready, 0);
        model_step();
        to_next();
        chk("lu_bubble", ex_valid, 0);
        cycle();
        idle();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_wa3", ex_wa3, 7);
        cycle();

        // BEQ x1,x2,+16 at 0x200
        idle(); if_valid = 1; if_instr = 32'h00208863; if_pc = 32'h200; rd1 = 5; rd2 = 5;
        to_neg();
        chk("beq_taken", pc_b_en, 1);
        chk("beq_target", pc_target, 32'h210);
        model_step(); to_next();
        rd2 = 6;
        to_neg();
        chk("beq_not_taken", pc_b_en, 0);
        model_step(); to_next();
        wb_we = 1; wb_wa = 2; wb_wd = 5;
        to_neg();
        chk("beq_fwd_taken", pc_b_en, 1);
        model_step(); to_next();
        idle(); cycle();

        // EX back-pressure: ADDI held for 3 cycles while JAL x1,+8 is offered
        if_valid = 1; if_instr = 32'hFFF00293; if_pc = 32'h2FC;
        cycle();
        ex_ready = 0; if_instr = 32'h008000EF; if_pc = 32'h300;
        for (int k = 0; k < 3; k++) begin
            to_neg();
            chk("hold_id_ready", id_ready, 0);
            chk("hold_pc_b_en", pc_b_en, 0);
            chk("hold_imm", ex_imm, 32'hFFFFFFFF);
            chk("hold_pc", ex_pc, 32'h2FC);
            model_step(); to_next();
        end
        ex_ready = 1;
        to_neg();
        chk("jal_redirect", pc_b_en, 1);
        chk("jal_target", pc_target, 32'h308);
        model_step(); to_next();
        idle();
        chk("jal_imm", ex_imm, 4);
        chk("jal_srca", ex_srcA_pc, 1);
        cycle();

        // flush while JALR offered
        if_valid = 1; flush = 1; if_instr = 32'h000100E7; if_pc = 32'h400; rd1 = 32'h1000;
        to_neg();
        chk("flush_pc_b_en", pc_b_en, 0);
        model_step(); to_next();
        idle();
        chk("flush_ex_valid", ex_valid, 0);

        // illegal opcode, then ADDI x0,x0,1
        if_valid = 1; if_instr = 32'h0000037F; if_pc = 32'h500;
        cycle();
        if_instr = 32'h00100013;
        chk("ill_flag", ex_illegal, 1);
        chk("ill_we_rf", ex_we_rf, 0);
        cycle();
        idle();
        chk("x0_we_rf", ex_we_rf, 0);
        chk("x0_valid", ex_valid, 1);
        cycle();

        // asynchronous reset mid-operation
        if_valid = 1; if_instr = 32'hFFF00293; if_pc = 32'h600;
        cycle();
        idle(); ex_ready = 0;
        #1 reset = 1;
        #1;
        chk("async_rst_valid", ex_valid, 0);
        chk("async_rst_imm", ex_imm, 0);
        m_valid = 0;
        exp_q.delete();
        to_next();
        reset = 0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!(if_valid && !id_ready && $urandom_range(0, 1) == 1)) begin
                if_instr = rand_instr();
                if_pc    = $urandom() & ~32'd3;
            end
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            rd1      = $urandom();
            rd2      = ($urandom_range(0, 3) == 0) ? rd1 : $urandom();
            wb_we    = $urandom_range(0, 1);
            wb_wa    = 5'($urandom_range(0, 7));
            wb_wd    = $urandom();
            cycle();
        end

        idle();
        repeat (3) cycle();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
